// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer and the decode/writeback logic around it.
package multdiv_sequencer_pkg;

  localparam logic [4:0] OPCODE_ALU = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  // Values written to rstatus (r30) when data_exception is raised
  localparam int unsigned RSTATUS_MULT_EXC = 4;
  localparam int unsigned RSTATUS_DIV_EXC  = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: synchronous clear, counts while enabled, flags the last iteration (WIDTH-1).
module iter_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal_c = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) unit with a stall-driving sequencer.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [1:0]       state, state_next;
  logic [PW-1:0]    shift_reg, shift_next;
  logic [WIDTH-1:0] operand_mag;
  logic             sign_neg;
  logic             start_mul, start_div, div_zero, iterating, iter_last_c;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [PW-1:0]    prod_signed;
  logic [WIDTH-1:0] quot_signed, fix_result;
  logic             fix_exc;

  assign start_mul = (state == ST_IDLE) && ctrl_MULT;
  assign start_div = (state == ST_IDLE) && !ctrl_MULT && ctrl_DIV;
  assign div_zero  = (operandB == '0);
  assign iterating = (state == ST_MUL) || (state == ST_DIV);
  assign mag_a     = operandA[WIDTH-1] ? (~operandA + WIDTH'(1)) : operandA;
  assign mag_b     = operandB[WIDTH-1] ? (~operandB + WIDTH'(1)) : operandB;

  iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_mul || start_div),
    .enable     (iterating),
    .terminal_c (iter_last_c)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ctrl_MULT)     state_next = ST_MUL;
        else if (ctrl_DIV) state_next = div_zero ? ST_DONE : ST_DIV;
      end
      ST_MUL, ST_DIV: if (iter_last_c) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // One iteration step: multiply keeps the multiplier in the low half, divide keeps remainder:quotient
  always_comb begin
    mul_sum    = {1'b0, shift_reg[PW-1:WIDTH]} + (shift_reg[0] ? {1'b0, operand_mag} : '0);
    div_diff   = shift_reg[PW-1:WIDTH-1] - {1'b0, operand_mag};
    shift_next = shift_reg;
    if (state == ST_MUL) begin
      shift_next = {mul_sum, shift_reg[WIDTH-1:1]};
    end else if (state == ST_DIV) begin
      shift_next = div_diff[WIDTH] ? {shift_reg[PW-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], shift_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up on the final step so results are valid in the DONE cycle
  always_comb begin
    prod_signed = sign_neg ? (~shift_next + PW'(1)) : shift_next;
    quot_signed = sign_neg ? (~shift_next[WIDTH-1:0] + WIDTH'(1)) : shift_next[WIDTH-1:0];
    if (state == ST_MUL) begin
      fix_result = prod_signed[WIDTH-1:0];
      fix_exc    = !((&prod_signed[PW-1:WIDTH-1]) || !(|prod_signed[PW-1:WIDTH-1]));
    end else begin
      fix_result = quot_signed;
      fix_exc    = !sign_neg && shift_next[WIDTH-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg      <= '0;
      operand_mag    <= '0;
      sign_neg       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      busy           <= (state_next != ST_IDLE);
      if (start_mul || start_div) begin
        shift_reg      <= {WIDTH'(0), start_mul ? mag_b : mag_a};
        operand_mag    <= start_mul ? mag_a : mag_b;
        sign_neg       <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
        data_result    <= '0;
        data_exception <= start_div && div_zero;
        data_resultRDY <= start_div && div_zero;
      end else if (iterating) begin
        shift_reg <= shift_next;
        if (iter_last_c) begin
          data_result    <= fix_result;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle signed multiply/divide unit with its own sequencing FSM. It sits beside the ALU in execute. Decode raises `ctrl_MULT` or `ctrl_DIV` for ALU-type instructions with ALUop 00110 or 00111. The block holds `busy` high to stall the pipeline, then returns a 32-bit result and an exception flag; the pipeline uses the flag to redirect the write to rstatus (r30).

## Interface
- `WIDTH`, 32: operand and result width; the iteration count equals `WIDTH`.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `ctrl_MULT`  in  1  start signed multiply; sampled only in IDLE.
- `ctrl_DIV`  in  1  start signed divide; sampled only in IDLE.
- `operandA`  in  WIDTH  multiplicand/dividend; latched on accepted start.
- `operandB`  in  WIDTH  multiplier/divisor; latched on accepted start.
- `data_result`  out  WIDTH  result; held from DONE until next accepted start.
- `data_exception`  out  1  overflow or divide-by-zero; held like `data_result`.
- `data_resultRDY`  out  1  one-cycle pulse in DONE.
- `busy`  out  1  high whenever state != IDLE; pipeline stall request.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE → MUL on `ctrl_MULT`.
- IDLE → DIV on `ctrl_DIV` with operandB != 0.
- IDLE → DONE on `ctrl_DIV` with operandB == 0. Result 0, exception 1, no iteration.
- Both starts high in IDLE: multiply wins, divide is dropped.
- Starts in MUL, DIV or DONE are ignored, not queued.
- On start:
  - Latch |A| and |B| as WIDTH-bit unsigned magnitudes; |−2^31| = 0x80000000.
  - Latch the result sign: signA XOR signB.
  - Clear the iteration counter.
- MUL: radix-2 shift-add on the 2·WIDTH product register, one bit per cycle. After WIDTH iterations → DONE.
- DIV: restoring division. Each cycle, shift the remainder:quotient pair left and trial-subtract |B|; on non-negative, keep the difference and set the quotient LSB. After WIDTH iterations → DONE.
- DONE (registered sign fix-up; outputs updated on entry):
  - Multiply: negate the 64-bit magnitude if sign set. `data_result` = low WIDTH bits. Exception if the upper WIDTH+1 bits of the signed product are not all equal.
  - Divide: negate the quotient if sign set; truncate toward zero; discard the remainder. The −2^31 / −1 case gives quotient 0x80000000 with exception 1.
  - Zero operand: multiply gives 0 with no exception.
- DONE → IDLE unconditionally after one cycle.

## Timing
- Start accepted at edge T (state IDLE):
  - MUL/DIV occupy T+1..T+WIDTH.
  - DONE at T+WIDTH+1: `data_resultRDY`=1 and result/exception valid.
  - IDLE at T+WIDTH+2.
- Latency: WIDTH+1 cycles from start to RDY (33 for WIDTH=32). Divide-by-zero: 1 cycle.
- `busy` is high T+1 through the DONE cycle inclusive. The earliest next start is the first IDLE cycle.
- `data_result` and `data_exception` change only on entry to DONE, on reset, or on the first cycle of a new operation (cleared to 0).
- Reset state: `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0, counter 0, state IDLE.
- Reset asserted mid-operation aborts it: no RDY pulse, outputs forced to reset values next edge.
- Reset wins over a simultaneous start.

## Structure
- Shared package holds:
  - Opcode constant 00000 (ALU-type).
  - ALUop constants MULT=00110 and DIV=00111.
  - rstatus codes MULT_EXC=4 and DIV_EXC=5, used by the pipeline's writeback mux.
  - State encoding IDLE/MUL/DIV/DONE (2 bits).
- Sub-module `iter_counter`: parameterised up-counter with synchronous clear and terminal-count output at WIDTH−1. Used by the FSM for the MUL/DIV exit condition.
- Multiply and divide share the 2·WIDTH shift register and the magnitude/negate logic.

## Test plan
- MULT, A=6, B=7, start at T → busy T+1..T+33, RDY pulse only at T+33, result 42, exception 0.
- MULT, A=−3 (0xFFFFFFFD), B=5 → result 0xFFFFFFF1 (−15), exception 0.
- MULT, A=0x00010000, B=0x00010000 → result 0, exception 1. Separately, A=0x80000000, B=1 → 0x80000000, exception 0.
- DIV, A=100, B=−7 → result −14 (0xFFFFFFF2), exception 0, RDY at T+33. Then DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
- DIV, A=5, B=0 → DONE at T+1, RDY at T+1, result 0, exception 1, busy high only at T+1.
- Start MULT, assert reset at T+10 → no RDY, all outputs 0 at T+11. Next, ctrl_MULT and ctrl_DIV together with A=9, B=3 → result 27. A start pulse during busy produces no second RDY.
